// File: rtl/bootrom_loader_pkg.sv
// bootrom_loader_pkg
//   Shared definitions for the boot ROM copy engine: the controller state
//   encoding, the ROM data width and the checksum accumulate helper.
package bootrom_loader_pkg;

    localparam int ROM_DW = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CHECK = 3'd3,
        ST_PASS  = 3'd4,
        ST_FAIL  = 3'd5
    } state_t;

    // Two's-complement checksum step: plain addition, wrapping modulo 2**32.
    function automatic logic [ROM_DW-1:0] csum_add(input logic [ROM_DW-1:0] acc,
                                                   input logic [ROM_DW-1:0] word);
        return acc + word;
    endfunction

endpackage

// File: rtl/bootrom_loader_if.sv
// bootrom_loader_if
//   Bundles the copy engine's control, boot ROM read port and SRAM write port.
//   master : the loader (drives ROM_EN/ROM_ADDR, SRAM_*, CPU_HOLD/DONE/ERR/CHECKSUM)
//   slave  : the system side (drives START and ROM_RDATA)
//   Signals:
//     START      system request to (re)start a copy (single cycle)
//     ROM_EN     ROM read enable
//     ROM_ADDR   ROM word address (AW_ADDR_W bits)
//     ROM_RDATA  ROM read data, valid the cycle after ROM_EN
//     SRAM_CS    SRAM select
//     SRAM_WE    SRAM write enable
//     SRAM_ADDR  SRAM word address (SRAM_AW bits)
//     SRAM_WDATA SRAM write data
//     CPU_HOLD   1 keeps the CPU in reset
//     DONE       copy finished, checksum good
//     ERR        copy finished, checksum bad
//     CHECKSUM   running sum of words copied so far
interface bootrom_loader_if #(
    parameter int AW_ADDR_W = 8,
    parameter int SRAM_AW   = 14
);

    logic                               START;
    logic                               ROM_EN;
    logic [AW_ADDR_W-1:0]               ROM_ADDR;
    logic [bootrom_loader_pkg::ROM_DW-1:0] ROM_RDATA;
    logic                               SRAM_CS;
    logic                               SRAM_WE;
    logic [SRAM_AW-1:0]                 SRAM_ADDR;
    logic [bootrom_loader_pkg::ROM_DW-1:0] SRAM_WDATA;
    logic                               CPU_HOLD;
    logic                               DONE;
    logic                               ERR;
    logic [bootrom_loader_pkg::ROM_DW-1:0] CHECKSUM;

    modport master (
        input  START, ROM_RDATA,
        output ROM_EN, ROM_ADDR, SRAM_CS, SRAM_WE, SRAM_ADDR, SRAM_WDATA,
               CPU_HOLD, DONE, ERR, CHECKSUM
    );

    modport slave (
        output START, ROM_RDATA,
        input  ROM_EN, ROM_ADDR, SRAM_CS, SRAM_WE, SRAM_ADDR, SRAM_WDATA,
               CPU_HOLD, DONE, ERR, CHECKSUM
    );

endinterface

// File: rtl/bootrom_loader.sv
// bootrom_loader
//   Boot-time copy engine. Reads NUM_WORDS words from the synchronous boot ROM
//   (one-cycle read latency), writes each into SRAM starting at SRAM_BASE one
//   cycle after its read, and accumulates a 32-bit sum. An image is good when
//   the sum of all words (the last being the checksum word) is zero; only then
//   is the CPU released from reset.
//   Ports:
//     CLK  single clock
//     RST  asynchronous active-high reset
//     bus  bootrom_loader_if.master (START, ROM port, SRAM port, status)
module bootrom_loader
    import bootrom_loader_pkg::*;
#(
    parameter int AW_ADDR_W  = 8,
    parameter int NUM_WORDS  = 256,
    parameter int SRAM_AW    = 14,
    parameter int SRAM_BASE  = 0,
    parameter int AUTO_START = 1
) (
    input  logic             CLK,
    input  logic             RST,
    bootrom_loader_if.master bus
);

    // One extra bit so a full 2**AW_ADDR_W image ends without wrapping to 0.
    localparam int                   CNT_W    = AW_ADDR_W + 1;
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(NUM_WORDS);
    localparam logic [SRAM_AW-1:0]   BASE     = SRAM_AW'(SRAM_BASE);

    state_t               state;
    logic                 auto_pend;
    logic [CNT_W-1:0]     cnt;          // address of the next read to issue
    logic                 vld_p0;       // ROM read issued this cycle
    logic [AW_ADDR_W-1:0] rom_addr_p0;
    logic                 vld_p1;       // ROM data returning, SRAM write this cycle
    logic [SRAM_AW-1:0]   wr_addr_p1;
    logic [ROM_DW-1:0]    checksum;
    logic                 done;
    logic                 err;
    logic                 cpu_hold;
    logic                 launch;

    // A copy starts from IDLE on START or the pending auto-start, and from
    // PASS/FAIL on START only; START is ignored while a copy is in flight.
    always_comb begin
        launch = 1'b0;
        case (state)
            ST_IDLE:          launch = bus.START | auto_pend;
            ST_PASS, ST_FAIL: launch = bus.START;
            default:          launch = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            auto_pend   <= (AUTO_START != 0);
            cnt         <= '0;
            vld_p0      <= 1'b0;
            rom_addr_p0 <= '0;
            vld_p1      <= 1'b0;
            wr_addr_p1  <= '0;
            checksum    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            cpu_hold    <= 1'b1;
        end else begin
            auto_pend <= 1'b0;
            if (launch) begin
                state       <= ST_READ;
                cnt         <= CNT_W'(1);
                vld_p0      <= 1'b1;
                rom_addr_p0 <= '0;
                vld_p1      <= 1'b0;
                checksum    <= '0;
                done        <= 1'b0;
                err         <= 1'b0;
                cpu_hold    <= 1'b1;
            end else begin
                case (state)
                    ST_READ: begin
                        // p0 -> p1: the word read now is written next cycle
                        vld_p1     <= 1'b1;
                        wr_addr_p1 <= BASE + SRAM_AW'(rom_addr_p0);
                        if (vld_p1) begin
                            checksum <= csum_add(checksum, bus.ROM_RDATA);
                        end
                        if (cnt == LAST_CNT) begin
                            state  <= ST_DRAIN;
                            vld_p0 <= 1'b0;
                        end else begin
                            rom_addr_p0 <= cnt[AW_ADDR_W-1:0];
                            cnt         <= cnt + CNT_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        // p1: last word written, pipeline empty afterwards
                        vld_p1   <= 1'b0;
                        checksum <= csum_add(checksum, bus.ROM_RDATA);
                        state    <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (checksum == '0) begin
                            state    <= ST_PASS;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= ST_FAIL;
                            err      <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                    ST_IDLE, ST_PASS, ST_FAIL: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.ROM_EN     = vld_p0;
    assign bus.ROM_ADDR   = rom_addr_p0;
    assign bus.SRAM_CS    = vld_p1;
    assign bus.SRAM_WE    = vld_p1;
    assign bus.SRAM_ADDR  = wr_addr_p1;
    assign bus.SRAM_WDATA = bus.ROM_RDATA;
    assign bus.CPU_HOLD   = cpu_hold;
    assign bus.DONE       = done;
    assign bus.ERR        = err;
    assign bus.CHECKSUM   = checksum;

endmodule

// File: tb/tb_bootrom_loader.sv
// tb_bootrom_loader
//   Three loader instances: A (4 words, auto start), B (256 words, auto start,
//   image wrapping the top of SRAM), C (4 words, no auto start). Expected
//   behaviour comes from a cycle timeline and image sums computed here.
module tb_bootrom_loader;
    import bootrom_loader_pkg::*;

    localparam int AW     = 8;
    localparam int SAW    = 14;
    localparam int SDEPTH = 1 << SAW;
    localparam int N_A    = 4;
    localparam int N_B    = 256;
    localparam int N_C    = 4;
    localparam int BASE_A = 0;
    localparam int BASE_B = 16300;
    localparam int BASE_C = 37;
    localparam int PW     = 1 + AW + 1 + 1 + SAW + 32 + 1 + 1 + 1 + 32;

    logic       clk = 1'b0;
    logic [2:0] rstv;
    int         sel;
    int         n_assert = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    bootrom_loader_if #(.AW_ADDR_W(AW), .SRAM_AW(SAW)) if_a ();
    bootrom_loader_if #(.AW_ADDR_W(AW), .SRAM_AW(SAW)) if_b ();
    bootrom_loader_if #(.AW_ADDR_W(AW), .SRAM_AW(SAW)) if_c ();

    bootrom_loader #(.AW_ADDR_W(AW), .NUM_WORDS(N_A), .SRAM_AW(SAW),
                     .SRAM_BASE(BASE_A), .AUTO_START(1))
        u_a (.CLK(clk), .RST(rstv[0]), .bus(if_a.master));
    bootrom_loader #(.AW_ADDR_W(AW), .NUM_WORDS(N_B), .SRAM_AW(SAW),
                     .SRAM_BASE(BASE_B), .AUTO_START(1))
        u_b (.CLK(clk), .RST(rstv[1]), .bus(if_b.master));
    bootrom_loader #(.AW_ADDR_W(AW), .NUM_WORDS(N_C), .SRAM_AW(SAW),
                     .SRAM_BASE(BASE_C), .AUTO_START(0))
        u_c (.CLK(clk), .RST(rstv[2]), .bus(if_c.master));

    // ROM images and SRAM/ROM behavioural models
    logic [31:0] romimg [3][256];
    logic [31:0] sram_a [SDEPTH];
    logic [31:0] sram_b [SDEPTH];
    logic [31:0] sram_c [SDEPTH];
    int          wcnt_a = 0;
    int          wcnt_b = 0;
    int          wcnt_c = 0;

    always @(posedge clk) if (if_a.ROM_EN) if_a.ROM_RDATA <= romimg[0][if_a.ROM_ADDR];
    always @(posedge clk) if (if_b.ROM_EN) if_b.ROM_RDATA <= romimg[1][if_b.ROM_ADDR];
    always @(posedge clk) if (if_c.ROM_EN) if_c.ROM_RDATA <= romimg[2][if_c.ROM_ADDR];

    always @(posedge clk) if (if_a.SRAM_CS && if_a.SRAM_WE) begin
        sram_a[if_a.SRAM_ADDR] <= if_a.SRAM_WDATA;
        wcnt_a <= wcnt_a + 1;
    end
    always @(posedge clk) if (if_b.SRAM_CS && if_b.SRAM_WE) begin
        sram_b[if_b.SRAM_ADDR] <= if_b.SRAM_WDATA;
        wcnt_b <= wcnt_b + 1;
    end
    always @(posedge clk) if (if_c.SRAM_CS && if_c.SRAM_WE) begin
        sram_c[if_c.SRAM_ADDR] <= if_c.SRAM_WDATA;
        wcnt_c <= wcnt_c + 1;
    end

    // Observation mux over the selected instance
    logic [PW-1:0]  pk_a, pk_b, pk_c, pk;
    logic           o_en, o_cs, o_we, o_hold, o_done, o_err;
    logic [AW-1:0]  o_raddr;
    logic [SAW-1:0] o_saddr;
    logic [31:0]    o_wdata, o_csum;

    assign pk_a = {if_a.ROM_EN, if_a.ROM_ADDR, if_a.SRAM_CS, if_a.SRAM_WE, if_a.SRAM_ADDR,
                   if_a.SRAM_WDATA, if_a.CPU_HOLD, if_a.DONE, if_a.ERR, if_a.CHECKSUM};
    assign pk_b = {if_b.ROM_EN, if_b.ROM_ADDR, if_b.SRAM_CS, if_b.SRAM_WE, if_b.SRAM_ADDR,
                   if_b.SRAM_WDATA, if_b.CPU_HOLD, if_b.DONE, if_b.ERR, if_b.CHECKSUM};
    assign pk_c = {if_c.ROM_EN, if_c.ROM_ADDR, if_c.SRAM_CS, if_c.SRAM_WE, if_c.SRAM_ADDR,
                   if_c.SRAM_WDATA, if_c.CPU_HOLD, if_c.DONE, if_c.ERR, if_c.CHECKSUM};
    assign pk   = (sel == 1) ? pk_b : (sel == 2) ? pk_c : pk_a;
    assign {o_en, o_raddr, o_cs, o_we, o_saddr, o_wdata, o_hold, o_done, o_err, o_csum} = pk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        case (s)
            1:       if_b.START = v;
            2:       if_c.START = v;
            default: if_a.START = v;
        endcase
    endtask

    function automatic logic [31:0] sram_rd(input int s, input logic [SAW-1:0] a);
        case (s)
            1:       return sram_b[a];
            2:       return sram_c[a];
            default: return sram_a[a];
        endcase
    endfunction

    function automatic int wcnt(input int s);
        case (s)
            1:       return wcnt_b;
            2:       return wcnt_c;
            default: return wcnt_a;
        endcase
    endfunction

    // Model: the image is good when its words sum to zero modulo 2**32.
    function automatic logic [31:0] img_sum(input int s, input int n);
        logic [31:0] acc = 32'd0;
        for (int i = 0; i < n; i++) acc = acc + romimg[s][i];
        return acc;
    endfunction

    task automatic make_valid(input int s, input int n);
        for (int i = 0; i < n - 1; i++) romimg[s][i] = $urandom;
        romimg[s][n-1] = 32'd0;
        romimg[s][n-1] = 32'd0 - img_sum(s, n - 1);
    endtask

    task automatic check_reset(input int s);
        sel = s;
        #1;
        chk($sformatf("rst%0d rom_en", s),   32'(o_en), 32'd0);
        chk($sformatf("rst%0d rom_addr", s), 32'(o_raddr), 32'd0);
        chk($sformatf("rst%0d sram_cs", s),  32'(o_cs), 32'd0);
        chk($sformatf("rst%0d sram_we", s),  32'(o_we), 32'd0);
        chk($sformatf("rst%0d sram_addr", s), 32'(o_saddr), 32'd0);
        chk($sformatf("rst%0d cpu_hold", s), 32'(o_hold), 32'd1);
        chk($sformatf("rst%0d done", s),     32'(o_done), 32'd0);
        chk($sformatf("rst%0d err", s),      32'(o_err), 32'd0);
        chk($sformatf("rst%0d checksum", s), o_csum, 32'd0);
    endtask

    // Called at a negedge. The current cycle is t (reset released or START
    // high); cycle t+c is checked against the expected timeline. 'extra' puts
    // a one-cycle START pulse in cycle t+extra.
    task automatic run_copy(input int s, input int n, input int base,
                            input bit by_rst, input int extra);
        logic [31:0] sum;
        bit          pass, e_en, e_cs, e_done, e_err;
        int          w0;
        sum  = img_sum(s, n);
        pass = (sum == 32'd0);
        w0   = wcnt(s);
        sel  = s;
        if (by_rst) rstv[s] = 1'b0;
        else        set_start(s, 1'b1);
        for (int c = 1; c <= n + 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            set_start(s, c == extra);
            e_en   = (c <= n);
            e_cs   = (c >= 2) && (c <= n + 1);
            e_done = (c >= n + 3) && pass;
            e_err  = (c >= n + 3) && !pass;
            chk($sformatf("i%0d c%0d rom_en", s, c), 32'(o_en), 32'(e_en));
            if (e_en) chk($sformatf("i%0d c%0d rom_addr", s, c), 32'(o_raddr), 32'(c - 1));
            chk($sformatf("i%0d c%0d sram_cs", s, c), 32'(o_cs), 32'(e_cs));
            chk($sformatf("i%0d c%0d sram_we", s, c), 32'(o_we), 32'(e_cs));
            if (e_cs) begin
                chk($sformatf("i%0d c%0d sram_addr", s, c), 32'(o_saddr),
                    32'((base + c - 2) % SDEPTH));
                chk($sformatf("i%0d c%0d sram_wdata", s, c), o_wdata, romimg[s][c-2]);
            end
            chk($sformatf("i%0d c%0d done", s, c), 32'(o_done), 32'(e_done));
            chk($sformatf("i%0d c%0d err", s, c), 32'(o_err), 32'(e_err));
            chk($sformatf("i%0d c%0d cpu_hold", s, c), 32'(o_hold), 32'(!e_done));
        end
        chk($sformatf("i%0d checksum", s), o_csum, sum);
        chk($sformatf("i%0d write count", s), 32'(wcnt(s) - w0), 32'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("i%0d sram[%0d]", s, (base + i) % SDEPTH),
                sram_rd(s, SAW'((base + i) % SDEPTH)), romimg[s][i]);
    endtask

    initial begin
        rstv = 3'b111;
        sel  = 0;
        set_start(0, 1'b0);
        set_start(1, 1'b0);
        set_start(2, 1'b0);
        romimg[0][0] = 32'd1;
        romimg[0][1] = 32'd2;
        romimg[0][2] = 32'd3;
        romimg[0][3] = 32'hFFFF_FFFA;
        make_valid(1, N_B);
        for (int i = 0; i < N_C; i++) romimg[2][i] = $urandom;

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) check_reset(s);
        @(negedge clk);

        // A: auto start after reset release, good image
        run_copy(0, N_A, BASE_A, 1'b1, -1);

        // A: corrupted word, restart from PASS, START pulse during READ ignored
        romimg[0][1] = 32'd5;
        run_copy(0, N_A, BASE_A, 1'b0, 2);

        // A: restart from FAIL with a random good image, START pulse in DRAIN
        make_valid(0, N_A);
        run_copy(0, N_A, BASE_A, 1'b0, N_A + 1);

        // A: reset while reading word 2, then auto restart from word 0
        make_valid(0, N_A);
        sel = 0;
        set_start(0, 1'b1);
        @(posedge clk); @(negedge clk);
        set_start(0, 1'b0);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("mid rom_addr", 32'(o_raddr), 32'd2);
        rstv[0] = 1'b1;
        check_reset(0);
        @(posedge clk); @(negedge clk);
        chk("held rom_en", 32'(o_en), 32'd0);
        run_copy(0, N_A, BASE_A, 1'b1, -1);

        // B: full-size image wrapping the SRAM top, START pulse in CHECK
        run_copy(1, N_B, BASE_B, 1'b1, N_B + 2);

        // C: no auto start, no ROM activity until START
        sel     = 2;
        rstv[2] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("idle c%0d rom_en", i), 32'(o_en), 32'd0);
        end
        chk("idle cpu_hold", 32'(o_hold), 32'd1);
        run_copy(2, N_C, BASE_C, 1'b0, -1);
        make_valid(2, N_C);
        run_copy(2, N_C, BASE_C, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
